// File: rtl/alu_nibble_sequencer.sv
// Multi-cycle front-end for a 4-bit 74181-style ALU. It accepts a wide request, feeds the ALU
// one nibble per clock (LSB first), ripples the active-low carry through a register and
// returns the assembled result over a valid/ready handshake.
module alu_nibble_sequencer #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid_in,
   output logic                   req_ready_out,
   input  logic [4*NIBBLES-1:0]   op_a_in,
   input  logic [4*NIBBLES-1:0]   op_b_in,
   input  logic [3:0]             s_in,
   input  logic                   M_in,
   input  logic                   Ci_inverse_in,
   output logic                   resp_valid_out,
   input  logic                   resp_ready_in,
   output logic [4*NIBBLES-1:0]   result_out,
   output logic                   Co_inverse_out,
   output logic                   AequalsB_out,
   output logic [3:0]             alu_a_out,
   output logic [3:0]             alu_b_out,
   output logic [3:0]             alu_s_out,
   output logic                   alu_M_out,
   output logic                   alu_Ci_inverse_out,
   input  logic [3:0]             alu_Y_in,
   input  logic                   alu_Co_inverse_in,
   input  logic                   alu_AequalsB_in
);

   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                       state_q, state_d;
   logic [IdxW-1:0]              idx_q;
   logic [NIBBLES-1:0][3:0]      a_q, b_q, result_q;
   logic [3:0]                   s_q;
   logic                         m_q;
   logic                         carry_q;
   logic                         eq_q;

   logic                         accept;
   logic                         last_nibble;
   logic                         resp_taken;

   assign accept      = (state_q == StIdle) & req_valid_in;
   assign last_nibble = (idx_q == IdxW'(NIBBLES - 1));
   assign resp_taken  = (state_q == StDone) & resp_ready_in;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (last_nibble) state_d = StDone;
         StDone:  if (resp_taken) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Operand latch, per-nibble result/flag accumulation and carry ripple
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         m_q      <= 1'b0;
         carry_q  <= 1'b1;
         idx_q    <= '0;
         result_q <= '0;
         eq_q     <= 1'b0;
      end else if (accept) begin
         a_q      <= op_a_in;
         b_q      <= op_b_in;
         s_q      <= s_in;
         m_q      <= M_in;
         carry_q  <= Ci_inverse_in;
         idx_q    <= '0;
         result_q <= '0;
         eq_q     <= 1'b1;
      end else if (state_q == StRun) begin
         result_q[idx_q] <= alu_Y_in;
         eq_q            <= eq_q & alu_AequalsB_in;
         // Logic mode ignores the ALU carry so the entry carry is simply held.
         if (!m_q) begin
            carry_q <= alu_Co_inverse_in;
         end
         idx_q <= idx_q + 1'b1;
      end
   end

   // Handshake outputs and ALU drive
   always_comb begin
      req_ready_out      = (state_q == StIdle);
      resp_valid_out     = (state_q == StDone);
      result_out         = result_q;
      Co_inverse_out     = m_q | carry_q;
      AequalsB_out       = eq_q;
      alu_a_out          = '0;
      alu_b_out          = '0;
      alu_s_out          = s_q;
      alu_M_out          = m_q;
      alu_Ci_inverse_out = carry_q;
      if (state_q == StRun) begin
         alu_a_out = a_q[idx_q];
         alu_b_out = b_q[idx_q];
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with a behavioural 74181 nibble model standing in for the ALU.
module tb_alu_nibble_sequencer;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk;
   logic          rst_n;
   logic          req_valid_in;
   logic          req_ready_out;
   logic [W-1:0]  op_a_in;
   logic [W-1:0]  op_b_in;
   logic [3:0]    s_in;
   logic          M_in;
   logic          Ci_inverse_in;
   logic          resp_valid_out;
   logic          resp_ready_in;
   logic [W-1:0]  result_out;
   logic          Co_inverse_out;
   logic          AequalsB_out;
   logic [3:0]    alu_a_out;
   logic [3:0]    alu_b_out;
   logic [3:0]    alu_s_out;
   logic          alu_M_out;
   logic          alu_Ci_inverse_out;
   logic [3:0]    alu_Y_in;
   logic          alu_Co_inverse_in;
   logic          alu_AequalsB_in;

   int total;
   int bad;

   alu_nibble_sequencer #(.NIBBLES(N)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_in       (req_valid_in),
      .req_ready_out      (req_ready_out),
      .op_a_in            (op_a_in),
      .op_b_in            (op_b_in),
      .s_in               (s_in),
      .M_in               (M_in),
      .Ci_inverse_in      (Ci_inverse_in),
      .resp_valid_out     (resp_valid_out),
      .resp_ready_in      (resp_ready_in),
      .result_out         (result_out),
      .Co_inverse_out     (Co_inverse_out),
      .AequalsB_out       (AequalsB_out),
      .alu_a_out          (alu_a_out),
      .alu_b_out          (alu_b_out),
      .alu_s_out          (alu_s_out),
      .alu_M_out          (alu_M_out),
      .alu_Ci_inverse_out (alu_Ci_inverse_out),
      .alu_Y_in           (alu_Y_in),
      .alu_Co_inverse_in  (alu_Co_inverse_in),
      .alu_AequalsB_in    (alu_AequalsB_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 74181 nibble (active-high data): F = X plus Y plus carry, logic mode F = X xor ~Y
   logic [3:0] nx, ny;
   logic [4:0] nsum;
   always_comb begin
      nx = alu_a_out | ({4{alu_s_out[0]}} & alu_b_out) | ({4{alu_s_out[1]}} & ~alu_b_out);
      ny = ({4{alu_s_out[2]}} & alu_a_out & ~alu_b_out) | ({4{alu_s_out[3]}} & alu_a_out & alu_b_out);
      nsum = {1'b0, nx} + {1'b0, ny} + {4'b0, ~alu_Ci_inverse_out};
      if (alu_M_out) begin
         alu_Y_in          = nx ^ ~ny;
         alu_Co_inverse_in = 1'b1;
      end else begin
         alu_Y_in          = nsum[3:0];
         alu_Co_inverse_in = ~nsum[4];
      end
      alu_AequalsB_in = (alu_Y_in == 4'hF);
   end

   // Whole-word reference: {Co_inverse, AequalsB, result}
   function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s, input logic m, input logic ci);
      logic [W-1:0] x, y, f;
      logic [W:0]   sum;
      logic         co;
      x   = a | ({W{s[0]}} & b) | ({W{s[1]}} & ~b);
      y   = ({W{s[2]}} & a & ~b) | ({W{s[3]}} & a & b);
      sum = {1'b0, x} + {1'b0, y} + (W+1)'(!ci);
      if (m) begin
         f  = x ^ ~y;
         co = 1'b1;
      end else begin
         f  = sum[W-1:0];
         co = ~sum[W];
      end
      return {co, (f == {W{1'b1}}), f};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready_out), 32'd1);
      chk({tag, " resp_valid"}, 32'(resp_valid_out), 32'd0);
      chk({tag, " result"}, 32'(result_out), 32'd0);
      chk({tag, " co_n"}, 32'(Co_inverse_out), 32'd1);
      chk({tag, " aeqb"}, 32'(AequalsB_out), 32'd0);
      chk({tag, " alu_a"}, 32'(alu_a_out), 32'd0);
      chk({tag, " alu_b"}, 32'(alu_b_out), 32'd0);
      chk({tag, " alu_s"}, 32'(alu_s_out), 32'd0);
      chk({tag, " alu_m"}, 32'(alu_M_out), 32'd0);
      chk({tag, " alu_ci_n"}, 32'(alu_Ci_inverse_out), 32'd1);
   endtask

   // Issue one request, wait for the response, hold it `hold` cycles, then consume it.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic ci, input int hold,
                         output logic [W-1:0] res, output logic co, output logic eq,
                         output int lat);
      int cyc;
      op_a_in       = a;
      op_b_in       = b;
      s_in          = s;
      M_in          = m;
      Ci_inverse_in = ci;
      req_valid_in  = 1'b1;
      cyc = 0;
      while (!req_ready_out && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("req_ready wait", 32'(req_ready_out), 32'd1);
      @(posedge clk); #1;
      req_valid_in = 1'b0;
      lat = 0;
      while (!resp_valid_out && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      repeat (hold) begin
         @(posedge clk); #1;
      end
      res = result_out;
      co  = Co_inverse_out;
      eq  = AequalsB_out;
      resp_ready_in = 1'b1;
      @(posedge clk); #1;
      resp_ready_in = 1'b0;
      chk("resp_valid after handshake", 32'(resp_valid_out), 32'd0);
      chk("req_ready after handshake", 32'(req_ready_out), 32'd1);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   s;
      logic         m;
      logic         ci;
      logic [W-1:0] res;
      logic         co;
      logic         eq;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] res;
      logic         co, eq;
      logic [W+1:0] exp;
      int           lat;

      vecs[0] = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0};
      vecs[1] = '{16'h000F, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0010, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[3] = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
      vecs[4] = '{16'h5A5B, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 16'hFF00, 1'b1, 1'b0};
      vecs[6] = '{16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hFF00, 1'b1, 1'b0};
      vecs[7] = '{16'hFFFF, 16'h1234, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[8] = '{16'h1234, 16'h5678, 4'b1100, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1};

      total = 0;
      bad   = 0;
      rst_n         = 1'b0;
      req_valid_in  = 1'b0;
      resp_ready_in = 1'b0;
      op_a_in       = '0;
      op_b_in       = '0;
      s_in          = '0;
      M_in          = 1'b0;
      Ci_inverse_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].ci, 0, res, co, eq, lat);
         chk($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].res));
         chk($sformatf("vec%0d co_n", i), 32'(co), 32'(vecs[i].co));
         chk($sformatf("vec%0d aeqb", i), 32'(eq), 32'(vecs[i].eq));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(N));
      end

      // Randomised operations against the whole-word model
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic [3:0]   rs;
         logic         rm, rci;
         ra  = W'($urandom);
         rb  = (i % 5 == 0) ? ra : W'($urandom);
         rs  = 4'($urandom);
         rm  = 1'($urandom);
         rci = 1'($urandom);
         exp = ref_op(ra, rb, rs, rm, rci);
         run_op(ra, rb, rs, rm, rci, int'($urandom_range(0, 2)), res, co, eq, lat);
         chk($sformatf("rnd%0d result", i), 32'(res), 32'(exp[W-1:0]));
         chk($sformatf("rnd%0d aeqb", i), 32'(eq), 32'(exp[W]));
         chk($sformatf("rnd%0d co_n", i), 32'(co), 32'(exp[W+1]));
         chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(N));
      end

      // Backpressure: response held while a new request waits
      op_a_in       = 16'h1234;
      op_b_in       = 16'h0FFF;
      s_in          = 4'b1001;
      M_in          = 1'b0;
      Ci_inverse_in = 1'b1;
      req_valid_in  = 1'b1;
      @(posedge clk); #1;
      req_valid_in = 1'b0;
      repeat (N) begin
         @(posedge clk); #1;
      end
      chk("bp resp_valid", 32'(resp_valid_out), 32'd1);
      op_a_in      = 16'h000F;
      op_b_in      = 16'h0001;
      req_valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp hold result", 32'(result_out), 32'h2233);
         chk("bp hold co_n", 32'(Co_inverse_out), 32'd1);
         chk("bp hold aeqb", 32'(AequalsB_out), 32'd0);
         chk("bp hold resp_valid", 32'(resp_valid_out), 32'd1);
         chk("bp req_ready low", 32'(req_ready_out), 32'd0);
      end
      resp_ready_in = 1'b1;
      @(posedge clk); #1;
      resp_ready_in = 1'b0;
      chk("bp after hs req_ready", 32'(req_ready_out), 32'd1);
      chk("bp after hs resp_valid", 32'(resp_valid_out), 32'd0);
      @(posedge clk); #1;
      req_valid_in = 1'b0;
      chk("bp pending accepted", 32'(req_ready_out), 32'd0);
      repeat (N) begin
         @(posedge clk); #1;
      end
      chk("bp second resp_valid", 32'(resp_valid_out), 32'd1);
      chk("bp second result", 32'(result_out), 32'h0010);
      resp_ready_in = 1'b1;
      @(posedge clk); #1;
      resp_ready_in = 1'b0;

      // Reset in the middle of an operation
      op_a_in       = 16'hABCD;
      op_b_in       = 16'h1111;
      s_in          = 4'b1001;
      M_in          = 1'b0;
      Ci_inverse_in = 1'b1;
      req_valid_in  = 1'b1;
      @(posedge clk); #1;
      req_valid_in = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("midop slice2 a", 32'(alu_a_out), 32'hB);
      rst_n = 1'b0;
      #1;
      chk_reset("midop reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no stale resp", 32'(resp_valid_out), 32'd0);
      end
      exp = ref_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b0);
      run_op(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b0, 1, res, co, eq, lat);
      chk("post reset result", 32'(res), 32'(exp[W-1:0]));
      chk("post reset co_n", 32'(co), 32'(exp[W+1]));
      chk("post reset latency", 32'(lat), 32'(N));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
